// File: rtl/tv_player_checker.sv
// Hardware test-vector player: applies {inputs, expected} vectors to a combinational DUT,
// compares after SETTLE cycles, counts and logs mismatches. Option: TV_CHECKER_STOP_ON_ERR_EN.
module tv_player_checker #(
    parameter int IN_W      = 3,
    parameter int OUT_W     = 2,
    parameter int SETTLE    = 1,
    parameter int CNT_W     = 32,
    parameter int LOG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          vec_valid,
    output logic                          vec_ready,
    input  logic [IN_W+OUT_W-1:0]         vec_data,
    input  logic                          vec_last,
    output logic [IN_W-1:0]               dut_in,
    input  logic [OUT_W-1:0]              dut_out,
    output logic [CNT_W-1:0]              vectornum,
    output logic [CNT_W-1:0]              errors,
    output logic                          done,
    output logic                          pass,
    output logic                          err_valid,
    input  logic                          err_ready,
    output logic [CNT_W+IN_W+2*OUT_W-1:0] err_data,
    output logic                          err_overflow
);

    localparam int ERR_W = CNT_W + IN_W + 2 * OUT_W;
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [7:0]       SETTLE_CNT = 8'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL  = (PTR_W + 1)'(LOG_DEPTH);
`ifdef TV_CHECKER_STOP_ON_ERR_EN
    localparam logic STOP_ON_ERR = 1'b1;
`else
    localparam logic STOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [IN_W-1:0]    r_dut_in;
    logic [OUT_W-1:0]   r_exp;
    logic               r_last;
    logic [7:0]         r_cnt;
    logic [CNT_W-1:0]   r_vectornum, r_errors;
    logic [ERR_W-1:0]   r_mem [LOG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]     r_fill;
    logic               r_overflow;

    logic               w_accept, w_compare, w_mismatch;
    logic               w_full, w_pop, w_push_ok;

    assign w_accept   = vec_valid && vec_ready;
    assign w_compare  = (r_state == ST_WAIT) && (r_cnt == 8'd1);
    assign w_mismatch = w_compare && (dut_out != r_exp);

    always_comb begin
        w_state_nxt = r_state;
        vec_ready   = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                vec_ready = 1'b1;
                if (w_accept) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_compare)
                    w_state_nxt = (r_last || (STOP_ON_ERR && w_mismatch)) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: done = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dut_in    <= '0;
            r_exp       <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_vectornum <= '0;
            r_errors    <= '0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_dut_in    <= '0;
            r_exp       <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_vectornum <= '0;
            r_errors    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dut_in <= vec_data[IN_W+OUT_W-1:OUT_W];
                r_exp    <= vec_data[OUT_W-1:0];
                r_last   <= vec_last;
                r_cnt    <= SETTLE_CNT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_compare && (r_vectornum != '1)) r_vectornum <= r_vectornum + CNT_ONE;
            if (w_mismatch && (r_errors != '1))   r_errors    <= r_errors + CNT_ONE;
        end
    end

    // Error log: show-ahead FIFO; a push while full only succeeds if a pop frees the slot.
    assign err_valid = (r_fill != '0);
    assign w_full    = (r_fill == FILL_FULL);
    assign w_pop     = err_valid && err_ready;
    assign w_push_ok = w_mismatch && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push_ok && !w_pop)      r_fill <= r_fill + FILL_ONE;
            else if (!w_push_ok && w_pop) r_fill <= r_fill - FILL_ONE;
            if (w_mismatch && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the fill count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_vectornum, r_dut_in, dut_out, r_exp};
    end

    assign err_data     = err_valid ? r_mem[r_rd_ptr] : '0;
    assign err_overflow = r_overflow;
    assign dut_in       = r_dut_in;
    assign vectornum    = r_vectornum;
    assign errors       = r_errors;
    assign pass         = done && (r_errors == '0);

endmodule

// File: doc/tv_player_checker.md
Name: tv_player_checker

Overview:
- Synthesizable hardware counterpart of the team's simulation self-checking bench.
- Accepts a stream of packed test vectors of the form {inputs, expected outputs} over a valid/ready handshake.
- Drives the inputs onto a combinational DUT, waits a programmable settle time, then compares the DUT outputs against the expected value.
- Counts applied vectors and mismatches, logs mismatches in a small error FIFO, and reports done/pass on the FPGA board.

Parameters:
- IN_W, 3, DUT input width; vector MSB field.
- OUT_W, 2, DUT output width; vector LSB field.
- SETTLE, 1, cycles from DUT input update to compare; legal range 1..255.
- CNT_W, 32, width of the vector and error counters.
- LOG_DEPTH, 4, error FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- clear  in  1  synchronous soft restart; same effect as reset, one cycle later.
- vec_valid  in  1  vector available.
- vec_ready  out  1  checker accepts vector this cycle.
- vec_data  in  IN_W+OUT_W  {inputs[IN_W-1:0], expected[OUT_W-1:0]}.
- vec_last  in  1  marks final vector of the run.
- dut_in  out  IN_W  registered drive to the DUT.
- dut_out  in  OUT_W  DUT response.
- vectornum  out  CNT_W  vectors checked.
- errors  out  CNT_W  mismatches found.
- done  out  1  run complete.
- pass  out  1  done and errors==0.
- err_valid  out  1  error FIFO not empty.
- err_ready  in  1  pop error FIFO.
- err_data  out  CNT_W+IN_W+2*OUT_W  {index, inputs, got, expected} of the oldest mismatch.
- err_overflow  out  1  sticky; a mismatch was dropped because the FIFO was full.

Behaviour:
- Reset/clear values:
  - State IDLE.
  - dut_in=0, vectornum=0, errors=0.
  - done=0, pass=0.
  - FIFO empty: err_valid=0, err_data=0.
  - err_overflow=0.
  - vec_ready=1 only in IDLE; it is a Moore output.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Handshake at edge k when vec_valid && vec_ready.
  - Latch dut_in<=inputs, exp<=expected, last<=vec_last, cnt<=SETTLE.
  - Go to WAIT.
  - No handshake: stay in IDLE and hold dut_in.
- WAIT:
  - vec_ready=0.
  - cnt decrements each edge.
  - At the edge where cnt==1 (edge k+SETTLE), sample dut_out and compare it with exp.
  - Then go to DONE if last, else IDLE.
  - Throughput is one vector per SETTLE+1 cycles.
- Compare rules:
  - vectornum increments on every compare.
  - On mismatch, errors increments and the FIFO pushes {vectornum pre-increment, dut_in, dut_out, exp}.
  - Both counters saturate at all-ones (no wrap).
- DONE:
  - done=1; pass=(errors==0).
  - vec_ready=0; vec_valid is ignored.
  - Held until reset or clear.
  - The FIFO can still be drained.
- Error FIFO:
  - Show-ahead: err_data is valid whenever err_valid=1.
  - Pop on err_valid && err_ready.
  - Push while full with no pop: the entry is dropped and err_overflow is set.
  - Push and pop in the same cycle while full: both succeed; no overflow.
  - Pop when empty: ignored.
- vec_last on a vector that also mismatches: the mismatch is counted and logged before DONE, so pass=0.
- Asynchronous reset in WAIT: the compare is abandoned, nothing is counted, and dut_in returns to 0.
- clear asserted together with a handshake: clear wins and the vector is not accepted.

Optional Feature:
- Macro: TV_CHECKER_STOP_ON_ERR_EN.
- Defined: the first mismatch forces WAIT→DONE regardless of vec_last. The mismatch is counted and logged; no further vectors are accepted.
- Undefined: mismatches never stop the run; only vec_last ends it.

Test Plan:
- Full-adder truth table:
  - Stimulus: 8 vectors 000_00 … 111_11 (inputs a,b,cin; expected cout,s); correct DUT; SETTLE=1; last on the 8th vector.
  - Response: vectornum=8, errors=0, done=1, pass=1, err_valid=0.
- Faulty DUT:
  - Stimulus: same 8 vectors with s forced to 0.
  - Response: errors=4, pass=0.
  - Error FIFO pops indices 1,2,4,7 with got/expected s=0/1.
- Overflow:
  - Stimulus: LOG_DEPTH=4, 6 mismatching vectors, err_ready=0.
  - Response: errors=6, err_overflow=1, 4 entries with indices 0..3.
- Handshake timing:
  - Stimulus: SETTLE=3, vec_valid held high.
  - Response: vec_ready high for 1 cycle in every 4; dut_in changes on the cycle after the handshake; compare 3 edges later.
- Reset mid-WAIT:
  - Stimulus: assert reset 1 cycle after a handshake.
  - Response: all outputs return to reset values immediately; vectornum stays 0 after release.
- TV_CHECKER_STOP_ON_ERR_EN:
  - Stimulus: 8 vectors with vector 2 wrong.
  - Response: done after vector 2, vectornum=3, errors=1, vec_ready=0 thereafter.
